// File: rtl/timer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared definitions for the generic AVR-style timer/counter:
//               clock-select encodings, waveform-generation mode constants,
//               TCCR field positions and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Clock-select (TCCR[2:0]) encodings; 110/111 are treated as stop.
    localparam logic [2:0] CS_STOP    = 3'b000;
    localparam logic [2:0] CS_DIV1    = 3'b001;
    localparam logic [2:0] CS_DIV8    = 3'b010;
    localparam logic [2:0] CS_DIV64   = 3'b011;
    localparam logic [2:0] CS_DIV256  = 3'b100;
    localparam logic [2:0] CS_DIV1024 = 3'b101;

    // Waveform-generation mode (TCCR[4:3]) encodings.
    localparam logic [1:0] WGM_NORMAL = 2'b00;
    localparam logic [1:0] WGM_CTC    = 2'b01;
    localparam logic [1:0] WGM_FPWM   = 2'b10;
    localparam logic [1:0] WGM_RSVD   = 2'b11;

    // TCCR field bit positions.
    localparam int TCCR_CS_LSB  = 0;
    localparam int TCCR_CS_MSB  = 2;
    localparam int TCCR_WGM_LSB = 3;
    localparam int TCCR_WGM_MSB = 4;
    localparam int TCCR_COM_BIT = 5;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_CTC    = 2'd1,
        MODE_FPWM   = 2'd2
    } timer_mode_e;

    // Reserved WGM encoding collapses onto normal mode.
    function automatic timer_mode_e decode_wgm(input logic [1:0] wgm);
        timer_mode_e mode;
        case (wgm)
            WGM_CTC:            mode = MODE_CTC;
            WGM_FPWM:           mode = MODE_FPWM;
            WGM_NORMAL,
            WGM_RSVD:           mode = MODE_NORMAL;
            default:            mode = MODE_NORMAL;
        endcase
        return mode;
    endfunction

    function automatic logic cs_running(input logic [2:0] cs);
        return (cs != CS_STOP) && (cs <= CS_DIV1024);
    endfunction

    // Terminal count of the prescaler divider (divisor - 1).
    function automatic logic [9:0] cs_terminal(input logic [2:0] cs);
        logic [9:0] term;
        case (cs)
            CS_DIV1:    term = 10'd0;
            CS_DIV8:    term = 10'd7;
            CS_DIV64:   term = 10'd63;
            CS_DIV256:  term = 10'd255;
            CS_DIV1024: term = 10'd1023;
            default:    term = 10'd0;
        endcase
        return term;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : timer_prescaler
// Description : 10-bit free-running clock divider producing a one-cycle
//               count tick at the rate selected by the clock-select field.
//               Held at zero while stopped; restart forces it back to zero.
// Revision    : 1.0 - initial release
// Ports       : clk      in  system clock
//               rst_n    in  asynchronous active-low reset
//               cs       in  [2:0] clock select (currently active value)
//               restart  in  clear divider on this edge (clock select changing)
//               tick     out one-cycle count enable
// ============================================================================
module timer_prescaler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] cs,
    input  logic       restart,
    output logic       tick
);
    import timer_pkg::*;

    logic [9:0] count;
    logic [9:0] terminal;
    logic       running;

    assign running  = cs_running(cs);
    assign terminal = cs_terminal(cs);
    // For /1 the terminal count is 0, so the tick is asserted every cycle.
    assign tick     = running && (count == terminal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 10'd0;
        end else if (!running || restart || (count == terminal)) begin
            count <= 10'd0;
        end else begin
            count <= count + 10'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer_generic.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : timer_generic
// Description : Parametrised AVR-style timer/counter with normal, CTC and
//               fast-PWM modes, compare output pin and interrupt requests.
// Revision    : 1.0 - initial release
// Options     : TIMER_OCR_DBUF_EN - double-buffered OCR; in fast PWM the
//               active compare value only updates on the MAX->0 wrap.
// Ports       : sysClock            in  system clock
//               rst_n               in  asynchronous active-low reset
//               TCNT/OCR/TCCR/TIMSK data + write enables (load next cycle)
//               TIFR_input/_we      in  write-1-to-clear flag data
//               clear_count         in  synchronous counter clear
//               *_output            out register contents (OCR = active)
//               OC_pin              out compare / PWM output
//               irq_ovf, irq_cmp    out masked overflow / compare requests
// ============================================================================
module timer_generic #(
    parameter int WIDTH   = 8,
    parameter int TOV_BIT = 0,
    parameter int OCF_BIT = 1
) (
    input  logic             sysClock,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] TCNT_data,
    input  logic [WIDTH-1:0] OCR_input,
    input  logic [7:0]       TCCR_input,
    input  logic [7:0]       TIMSK_input,
    input  logic [7:0]       TIFR_input,
    input  logic             TCNT_write_enable,
    input  logic             OCR_write_enable,
    input  logic             TCCR_write_enable,
    input  logic             TIMSK_write_enable,
    input  logic             TIFR_write_enable,
    input  logic             clear_count,
    output logic [WIDTH-1:0] TCNT_output,
    output logic [WIDTH-1:0] OCR_output,
    output logic [7:0]       TCCR_output,
    output logic [7:0]       TIMSK_output,
    output logic [7:0]       TIFR_output,
    output logic             OC_pin,
    output logic             irq_ovf,
    output logic             irq_cmp
);
    import timer_pkg::*;

    localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_COUNT = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] tcnt, tcnt_next;
    logic [WIDTH-1:0] ocr_active, ocr_active_next;
    logic [7:0]       tccr, timsk, tifr, tifr_next;
    logic [7:0]       flag_set, flag_clr;
    logic             oc_state, oc_next;

    logic [2:0]       cs;
    logic             com;
    timer_mode_e      mode;
    logic             tick, restart;
    logic             count_en, at_max, match, ovf_evt, cmp_evt;

    assign cs   = tccr[TCCR_CS_MSB:TCCR_CS_LSB];
    assign com  = tccr[TCCR_COM_BIT];
    assign mode = decode_wgm(tccr[TCCR_WGM_MSB:TCCR_WGM_LSB]);

    // Restart the divider only when the clock select actually changes.
    assign restart = TCCR_write_enable &&
                     (TCCR_input[TCCR_CS_MSB:TCCR_CS_LSB] != cs);

    timer_prescaler u_prescaler (
        .clk     (sysClock),
        .rst_n   (rst_n),
        .cs      (cs),
        .restart (restart),
        .tick    (tick)
    );

    // A clear or software load owns TCNT this cycle: the tick is dropped
    // entirely, so no count, no overflow and no compare match.
    assign count_en = tick && !clear_count && !TCNT_write_enable;
    assign at_max   = (tcnt == MAX_COUNT);
    assign match    = (tcnt == ocr_active);
    // In every mode TOV only comes from the MAX->0 roll-over; in CTC that
    // means OCR == MAX, or a counter that was loaded above OCR.
    assign ovf_evt  = count_en && at_max;
    assign cmp_evt  = count_en && match;

    always_comb begin
        tcnt_next = tcnt;
        if (clear_count) begin
            tcnt_next = '0;
        end else if (TCNT_write_enable) begin
            tcnt_next = TCNT_data;
        end else if (count_en) begin
            if ((mode == MODE_CTC) && match) begin
                tcnt_next = '0;
            end else begin
                tcnt_next = tcnt + ONE_COUNT;
            end
        end
    end

    // Hardware set wins over a simultaneous software clear.
    always_comb begin
        flag_set          = 8'h00;
        flag_set[TOV_BIT] = ovf_evt;
        flag_set[OCF_BIT] = cmp_evt;
        flag_clr          = TIFR_write_enable ? TIFR_input : 8'h00;
        tifr_next         = (tifr & ~flag_clr) | flag_set;
    end

    // Output-compare state. It is held at 0 while COM is off so that enabling
    // COM always starts from a known level.
    always_comb begin
        oc_next = oc_state;
        if (!com) begin
            oc_next = 1'b0;
        end else if (count_en) begin
            if (mode == MODE_FPWM) begin
                // Set as TCNT rolls to 0; this takes precedence so that
                // OCR == MAX never clears the pin.
                if (at_max) begin
                    oc_next = 1'b1;
                end else if (match) begin
                    oc_next = 1'b0;
                end
            end else if (match) begin
                oc_next = ~oc_state;
            end
        end
    end

`ifdef TIMER_OCR_DBUF_EN
    logic [WIDTH-1:0] ocr_buf, ocr_buf_next;

    always_comb begin
        ocr_buf_next    = OCR_write_enable ? OCR_input : ocr_buf;
        ocr_active_next = ocr_active;
        if (mode != MODE_FPWM) begin
            ocr_active_next = ocr_buf_next;
        end else if (ovf_evt) begin
            ocr_active_next = ocr_buf_next;
        end
    end

    always_ff @(posedge sysClock or negedge rst_n) begin
        if (!rst_n) begin
            ocr_buf <= '0;
        end else begin
            ocr_buf <= ocr_buf_next;
        end
    end
`else
    always_comb begin
        ocr_active_next = OCR_write_enable ? OCR_input : ocr_active;
    end
`endif

    always_ff @(posedge sysClock or negedge rst_n) begin
        if (!rst_n) begin
            tcnt       <= '0;
            ocr_active <= '0;
            tccr       <= 8'h00;
            timsk      <= 8'h00;
            tifr       <= 8'h00;
            oc_state   <= 1'b0;
        end else begin
            tcnt       <= tcnt_next;
            ocr_active <= ocr_active_next;
            tifr       <= tifr_next;
            oc_state   <= oc_next;
            if (TCCR_write_enable) begin
                tccr <= TCCR_input;
            end
            if (TIMSK_write_enable) begin
                timsk <= TIMSK_input;
            end
        end
    end

    assign TCNT_output  = tcnt;
    assign OCR_output   = ocr_active;
    assign TCCR_output  = tccr;
    assign TIMSK_output = timsk;
    assign TIFR_output  = tifr;
    // OCR == MAX in fast PWM is a constant-high output, even before the
    // first wrap has set the registered state.
    assign OC_pin       = com && (oc_state ||
                          ((mode == MODE_FPWM) && (ocr_active == MAX_COUNT)));
    assign irq_ovf      = tifr[TOV_BIT] & timsk[TOV_BIT];
    assign irq_cmp      = tifr[OCF_BIT] & timsk[OCF_BIT];

endmodule
`default_nettype wire

// File: tb/tb_timer_generic.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_timer_generic
// Description : Directed self-checking bench for timer_generic. One 8-bit
//               instance (normal / flags / priority / CTC) and one 16-bit
//               instance (fast PWM duty, OCR buffering), then async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_generic;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-bit instance stimulus / observation
    logic [7:0] a_tcnt_d, a_ocr_d, a_tccr_d, a_timsk_d, a_tifr_d;
    logic       a_tcnt_we, a_ocr_we, a_tccr_we, a_timsk_we, a_tifr_we, a_clr;
    logic [7:0] a_tcnt, a_ocr, a_tccr, a_timsk, a_tifr;
    logic       a_oc, a_iovf, a_icmp;

    // 16-bit instance (TOV at bit 2, OCF at bit 4)
    logic [15:0] b_tcnt_d, b_ocr_d;
    logic [7:0]  b_tccr_d, b_timsk_d, b_tifr_d;
    logic        b_tcnt_we, b_ocr_we, b_tccr_we, b_timsk_we, b_tifr_we, b_clr;
    logic [15:0] b_tcnt, b_ocr;
    logic [7:0]  b_tccr, b_timsk, b_tifr;
    logic        b_oc, b_iovf, b_icmp;

    timer_generic #(.WIDTH(8), .TOV_BIT(0), .OCF_BIT(1)) u_dut8 (
        .sysClock(clk), .rst_n(rst_n),
        .TCNT_data(a_tcnt_d), .OCR_input(a_ocr_d), .TCCR_input(a_tccr_d),
        .TIMSK_input(a_timsk_d), .TIFR_input(a_tifr_d),
        .TCNT_write_enable(a_tcnt_we), .OCR_write_enable(a_ocr_we),
        .TCCR_write_enable(a_tccr_we), .TIMSK_write_enable(a_timsk_we),
        .TIFR_write_enable(a_tifr_we), .clear_count(a_clr),
        .TCNT_output(a_tcnt), .OCR_output(a_ocr), .TCCR_output(a_tccr),
        .TIMSK_output(a_timsk), .TIFR_output(a_tifr), .OC_pin(a_oc),
        .irq_ovf(a_iovf), .irq_cmp(a_icmp)
    );

    timer_generic #(.WIDTH(16), .TOV_BIT(2), .OCF_BIT(4)) u_dut16 (
        .sysClock(clk), .rst_n(rst_n),
        .TCNT_data(b_tcnt_d), .OCR_input(b_ocr_d), .TCCR_input(b_tccr_d),
        .TIMSK_input(b_timsk_d), .TIFR_input(b_tifr_d),
        .TCNT_write_enable(b_tcnt_we), .OCR_write_enable(b_ocr_we),
        .TCCR_write_enable(b_tccr_we), .TIMSK_write_enable(b_timsk_we),
        .TIFR_write_enable(b_tifr_we), .clear_count(b_clr),
        .TCNT_output(b_tcnt), .OCR_output(b_ocr), .TCCR_output(b_tccr),
        .TIMSK_output(b_timsk), .TIFR_output(b_tifr), .OC_pin(b_oc),
        .irq_ovf(b_iovf), .irq_cmp(b_icmp)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; return 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_tcnt_we = 0; a_ocr_we = 0; a_tccr_we = 0;
        a_timsk_we = 0; a_tifr_we = 0; a_clr = 0;
    endtask

    task automatic idle_b();
        b_tcnt_we = 0; b_ocr_we = 0; b_tccr_we = 0;
        b_timsk_we = 0; b_tifr_we = 0; b_clr = 0;
    endtask

    int high_cnt;

    initial begin
        rst_n = 1'b0;
        a_tcnt_d = '0; a_ocr_d = '0; a_tccr_d = '0; a_timsk_d = '0; a_tifr_d = '0;
        b_tcnt_d = '0; b_ocr_d = '0; b_tccr_d = '0; b_timsk_d = '0; b_tifr_d = '0;
        idle_a();
        idle_b();
        step(2);

        // ---------------- reset state ----------------
        check_val("rst_tcnt8", a_tcnt, 0);
        check_val("rst_tccr8", a_tccr, 0);
        check_val("rst_tifr8", a_tifr, 0);
        check_val("rst_oc8",   a_oc,   0);
        check_val("rst_tcnt16", b_tcnt, 0);
        rst_n = 1'b1;
        step(1);

        // ---------------- normal mode, /1, overflow ----------------
        a_tccr_d = 8'h01; a_tccr_we = 1;
        a_timsk_d = 8'h01; a_timsk_we = 1;
        a_tcnt_d = 8'hFE; a_tcnt_we = 1;
        step(1);
        idle_a();
        check_val("norm_load", a_tcnt, 8'hFE);
        step(1);
        check_val("norm_ff", a_tcnt, 8'hFF);
        check_val("norm_no_tov", a_tifr, 8'h00);
        step(1);
        check_val("norm_wrap", a_tcnt, 8'h00);
        check_val("norm_tov", a_tifr, 8'h01);
        check_val("norm_irq_ovf", a_iovf, 1);
        step(1);  // TCNT==OCR==0 on this tick -> OCF
        check_val("norm_ocf", a_tifr, 8'h03);
        check_val("norm_irq_cmp_masked", a_icmp, 0);

        // ---------------- TIFR clear same cycle as overflow ----------------
        a_tcnt_d = 8'hFE; a_tcnt_we = 1;
        step(1);
        idle_a();
        step(1);
        check_val("clr_pre_ff", a_tcnt, 8'hFF);
        a_tifr_d = 8'h03; a_tifr_we = 1;
        step(1);
        idle_a();
        check_val("clr_tov_kept", a_tifr, 8'h01);
        check_val("clr_wrap", a_tcnt, 8'h00);

        // ---------------- write / clear priority ----------------
        // TCNT==OCR==0 and tick this cycle, but the write suppresses match.
        a_tcnt_d = 8'h00; a_tcnt_we = 1;
        a_tifr_d = 8'h03; a_tifr_we = 1;
        step(1);
        idle_a();
        check_val("wr_no_match_flags", a_tifr, 8'h00);
        a_tcnt_d = 8'h80; a_tcnt_we = 1;
        step(1);
        idle_a();
        check_val("wr_value", a_tcnt, 8'h80);
        check_val("wr_no_match_flags2", a_tifr, 8'h00);
        a_tcnt_d = 8'h10; a_tcnt_we = 1; a_clr = 1;
        step(1);
        idle_a();
        check_val("clear_wins", a_tcnt, 8'h00);
        step(1);
        check_val("match_after_clear", a_tifr, 8'h02);
        check_val("count_after_clear", a_tcnt, 8'h01);
        a_tcnt_d = 8'hFF; a_tcnt_we = 1;
        step(1);
        a_tcnt_d = 8'h55;  // write again while sitting at MAX with a tick
        step(1);
        idle_a();
        check_val("wr_at_max_value", a_tcnt, 8'h55);
        check_val("wr_at_max_no_tov", a_tifr, 8'h02);

        // ---------------- CTC, OCR=9, /8, COM=1 ----------------
        a_tccr_d = 8'h2A; a_tccr_we = 1;
        a_timsk_d = 8'h03; a_timsk_we = 1;
        a_ocr_d = 8'd9; a_ocr_we = 1;
        a_tcnt_d = 8'h00; a_tcnt_we = 1;
        a_tifr_d = 8'hFF; a_tifr_we = 1;
        step(1);
        idle_a();
        check_val("ctc_start_flags", a_tifr, 8'h00);
        check_val("ctc_ocr", a_ocr, 8'd9);
        step(3);
        check_val("ctc_prescale_hold", a_tcnt, 8'h00);
        step(76);   // 79 edges after the load
        check_val("ctc_top", a_tcnt, 8'd9);
        check_val("ctc_oc_before", a_oc, 0);
        step(1);    // edge 80: match -> 0
        check_val("ctc_wrap", a_tcnt, 8'h00);
        check_val("ctc_ocf", a_tifr, 8'h02);
        check_val("ctc_irq_cmp", a_icmp, 1);
        check_val("ctc_oc_toggle1", a_oc, 1);
        a_tifr_d = 8'h02; a_tifr_we = 1;
        step(1);
        idle_a();
        check_val("ctc_ocf_cleared", a_tifr, 8'h00);
        step(78);   // edge 159
        check_val("ctc_top2", a_tcnt, 8'd9);
        check_val("ctc_no_ocf_yet", a_tifr, 8'h00);
        step(1);    // edge 160
        check_val("ctc_wrap2", a_tcnt, 8'h00);
        check_val("ctc_ocf2", a_tifr, 8'h02);
        check_val("ctc_oc_toggle2", a_oc, 0);

        // ---------------- fast PWM, 16-bit, OCR=0x4000 ----------------
        b_tccr_d = 8'h31; b_tccr_we = 1;
        b_ocr_d = 16'h4000; b_ocr_we = 1;
        b_tcnt_d = 16'hFFF0; b_tcnt_we = 1;
        step(1);
        idle_b();
        check_val("pwm_load", b_tcnt, 16'hFFF0);
        check_val("pwm_oc_low_before_wrap", b_oc, 0);
        step(16);
        check_val("pwm_wrap", b_tcnt, 16'h0000);
        check_val("pwm_tov_bit2", b_tifr, 8'h04);
        check_val("pwm_oc_set", b_oc, 1);
        high_cnt = 0;
        for (int i = 0; i < 65536; i++) begin
            if (b_oc) high_cnt++;
            step(1);
        end
        check_val("pwm_high_cycles", high_cnt, 32'h4001);
        check_val("pwm_flags_period", b_tifr, 8'h14);
        check_val("pwm_wrap2", b_tcnt, 16'h0000);

        // ---------------- OCR write mid-period ----------------
        b_ocr_d = 16'h0100; b_ocr_we = 1;
        step(1);
        idle_b();
`ifdef TIMER_OCR_DBUF_EN
        check_val("ocr_mid_period", b_ocr, 16'h4000);
`else
        check_val("ocr_mid_period", b_ocr, 16'h0100);
`endif
        b_tcnt_d = 16'hFFFE; b_tcnt_we = 1;
        step(1);
        idle_b();
        step(2);
        check_val("ocr_after_wrap_tcnt", b_tcnt, 16'h0000);
        check_val("ocr_after_wrap", b_ocr, 16'h0100);

        // ---------------- asynchronous reset mid-count ----------------
        step(5);
        rst_n = 1'b0;
        #1;
        check_val("arst_tcnt8", a_tcnt, 0);
        check_val("arst_tccr8", a_tccr, 0);
        check_val("arst_oc8",   a_oc,   0);
        check_val("arst_ocr16", b_ocr,  0);
        check_val("arst_tifr16", b_tifr, 0);
        rst_n = 1'b1;
        step(10);
        check_val("arst_stays_stopped", a_tcnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
